// File: rtl/fetch_pkg.sv
// Shared constants and types for the Y86-64 fetch sequencer.
package fetch_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_INS = 2'd2,
        STAT_ADR = 2'd3
    } stat_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_OP,
        FETCH_REG,
        FETCH_VALC,
        DONE,
        STOP
    } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Byte-wide instruction memory request/response bus.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [7:0]        rdata;
    logic              err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/fetch_len_decode.sv
// Combinational Y86-64 instruction length decoder.
module fetch_len_decode
    import fetch_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic       need_regids_o,
    output logic       need_valc_o,
    output logic       instr_valid_o
);

    always_comb begin
        need_regids_o = 1'b0;
        need_valc_o   = 1'b0;
        instr_valid_o = 1'b0;
        case (icode_i)
            IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids_o = 1'b1;
            default: need_regids_o = 1'b0;
        endcase
        case (icode_i)
            IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL: need_valc_o = 1'b1;
            default: need_valc_o = 1'b0;
        endcase
        case (icode_i)
            IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
            IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ: instr_valid_o = 1'b1;
            default: instr_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch controller: reads opcode, register and valC bytes one at a
// time from byte-wide memory and presents a single instruction bundle to decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_sequencer_if.master    imem,
    input  logic                 redirect_valid_i,
    input  logic [ADDR_W-1:0]    redirect_pc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [3:0]           out_icode_o,
    output logic [3:0]           out_ifun_o,
    output logic [3:0]           out_ra_o,
    output logic [3:0]           out_rb_o,
    output logic [63:0]          out_valc_o,
    output logic [ADDR_W-1:0]    out_pc_o,
    output logic [ADDR_W-1:0]    out_valp_o,
    output logic [1:0]           stat_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] valp_q, valp_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic              inflight_q, inflight_d;
    logic              drop_q, drop_d;
    logic [3:0]        icode_q, icode_d;
    logic [3:0]        ifun_q, ifun_d;
    logic [3:0]        ra_q, ra_d;
    logic [3:0]        rb_q, rb_d;
    logic [63:0]       valc_q, valc_d;
    stat_e             stat_q, stat_d;

    logic [3:0]        dec_icode;
    logic              need_regids, need_valc, instr_valid;
    logic [ADDR_W-1:0] addr_off, valp_calc;
    logic              grant, resp, take;

    // In FETCH_OP the opcode byte on the bus is decoded directly; later states reuse it.
    assign dec_icode = (state_q == FETCH_OP) ? imem.rdata[7:4] : icode_q;

    fetch_len_decode u_len_decode (
        .icode_i       (dec_icode),
        .need_regids_o (need_regids),
        .need_valc_o   (need_valc),
        .instr_valid_o (instr_valid)
    );

    always_comb begin
        addr_off = '0;
        case (state_q)
            FETCH_REG:  addr_off = ADDR_W'(1);
            FETCH_VALC: addr_off = ADDR_W'(1) + ADDR_W'(need_regids) + ADDR_W'(byte_cnt_q);
            default:    addr_off = '0;
        endcase
    end

    assign valp_calc = pc_q + ADDR_W'(1) + ADDR_W'(need_regids) + ADDR_W'({need_valc, 3'b000});

    assign imem.req  = (state_q inside {FETCH_OP, FETCH_REG, FETCH_VALC}) && !inflight_q;
    assign imem.addr = pc_q + addr_off;

    assign grant = imem.req && imem.gnt;
    assign resp  = inflight_q && imem.rvalid;
    assign take  = resp && !drop_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valp_d     = valp_q;
        byte_cnt_d = byte_cnt_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        icode_d    = icode_q;
        ifun_d     = ifun_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        valc_d     = valc_q;
        stat_d     = stat_q;

        if (resp) begin
            inflight_d = 1'b0;
            drop_d     = 1'b0;
        end
        if (grant) inflight_d = 1'b1;

        unique case (state_q)
            IDLE: state_d = FETCH_OP;
            FETCH_OP: begin
                if (take) begin
                    icode_d    = imem.rdata[7:4];
                    ifun_d     = imem.rdata[3:0];
                    ra_d       = 4'hF;
                    rb_d       = 4'hF;
                    valc_d     = '0;
                    valp_d     = valp_calc;
                    byte_cnt_d = '0;
                    stat_d     = STAT_AOK;
                    state_d    = DONE;
                    if (imem.err) begin
                        stat_d = STAT_ADR;
                    end else if (!instr_valid) begin
                        stat_d = STAT_INS;
                    end else if (imem.rdata[7:4] == IHALT) begin
                        stat_d = STAT_HLT;
                    end else if (need_regids) begin
                        state_d = FETCH_REG;
                    end else if (need_valc) begin
                        state_d = FETCH_VALC;
                    end
                end
            end
            FETCH_REG: begin
                if (take) begin
                    if (imem.err) begin
                        stat_d  = STAT_ADR;
                        state_d = DONE;
                    end else begin
                        ra_d    = imem.rdata[7:4];
                        rb_d    = imem.rdata[3:0];
                        state_d = need_valc ? FETCH_VALC : DONE;
                    end
                end
            end
            FETCH_VALC: begin
                if (take) begin
                    if (imem.err) begin
                        stat_d  = STAT_ADR;
                        state_d = DONE;
                    end else begin
                        valc_d[{byte_cnt_q, 3'b000} +: 8] = imem.rdata;
                        if (byte_cnt_q == 3'd7) state_d = DONE;
                        else                    byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    if (stat_q == STAT_AOK) begin
                        pc_d    = valp_q;
                        state_d = FETCH_OP;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            STOP: state_d = STOP;
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything, including a same-cycle accept; a read still
        // outstanding afterwards must be swallowed when it returns.
        if (redirect_valid_i) begin
            pc_d       = redirect_pc_i;
            byte_cnt_d = '0;
            state_d    = FETCH_OP;
            if ((inflight_q && !imem.rvalid) || grant) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            valp_q     <= '0;
            byte_cnt_q <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            icode_q    <= '0;
            ifun_q     <= '0;
            ra_q       <= 4'hF;
            rb_q       <= 4'hF;
            valc_q     <= '0;
            stat_q     <= STAT_AOK;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valp_q     <= valp_d;
            byte_cnt_q <= byte_cnt_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            icode_q    <= icode_d;
            ifun_q     <= ifun_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            valc_q     <= valc_d;
            stat_q     <= stat_d;
        end
    end

    assign out_valid_o = (state_q == DONE);
    assign out_icode_o = icode_q;
    assign out_ifun_o  = ifun_q;
    assign out_ra_o    = ra_q;
    assign out_rb_o    = rb_q;
    assign out_valc_o  = valc_q;
    assign out_pc_o    = pc_q;
    assign out_valp_o  = valp_q;
    assign stat_o      = stat_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a byte memory responder of adjustable latency.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_icode, out_ifun, out_ra, out_rb;
    logic [63:0] out_valc, out_pc, out_valp;
    logic [1:0]  stat;

    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic [7:0]  mem [0:2047];
    logic [63:0] gq[$];
    int          lat = 1;
    logic        err_en = 1'b0;
    logic [63:0] err_addr = '0;
    logic        pend = 1'b0;
    logic [63:0] paddr = '0;
    int          cnt = 0;

    fetch_sequencer_if #(.ADDR_W(64)) imem_bus ();

    fetch_sequencer #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (imem_bus),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_icode_o      (out_icode),
        .out_ifun_o       (out_ifun),
        .out_ra_o         (out_ra),
        .out_rb_o         (out_rb),
        .out_valc_o       (out_valc),
        .out_pc_o         (out_pc),
        .out_valp_o       (out_valp),
        .stat_o           (stat)
    );

    always #5 clk = ~clk;

    assign imem_bus.gnt = imem_bus.req;

    always @(posedge clk) begin
        imem_bus.rvalid <= 1'b0;
        imem_bus.err    <= 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                imem_bus.rvalid <= 1'b1;
                imem_bus.rdata  <= mem[paddr[10:0]];
                imem_bus.err    <= err_en && (paddr == err_addr);
                pend            <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (imem_bus.req && imem_bus.gnt) begin
            gq.push_back(imem_bus.addr);
            if (lat == 1) begin
                imem_bus.rvalid <= 1'b1;
                imem_bus.rdata  <= mem[imem_bus.addr[10:0]];
                imem_bus.err    <= err_en && (imem_bus.addr == err_addr);
            end else begin
                pend  <= 1'b1;
                paddr <= imem_bus.addr;
                cnt   <= lat - 2;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic count_req(input int cycles, output int reqs);
        reqs = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (imem_bus.req) reqs++;
        end
    endtask

    initial begin
        int n, g0, g1, reqs, viol;
        logic ok, stale;

        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[0] = 8'h10;
        mem[1] = 8'h10;
        mem[11'h100] = 8'h30;
        mem[11'h101] = 8'hF2;
        for (int i = 0; i < 8; i++) mem[11'h102 + i] = 8'(i + 1);
        mem[11'h10A] = 8'h00;
        mem[11'h200] = 8'hC0;
        mem[11'h300] = 8'h50;
        mem[11'h301] = 8'h12;
        mem[11'h400] = 8'h50;
        mem[11'h401] = 8'h12;
        mem[11'h40]  = 8'h10;
        mem[11'h41]  = 8'hC0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_req", {63'd0, imem_bus.req}, 64'd0);
        chk("rst_ra", {60'd0, out_ra}, 64'hF);
        chk("rst_rb", {60'd0, out_rb}, 64'hF);
        chk("rst_stat", {62'd0, stat}, 64'd0);
        chk("rst_valc", out_valc, 64'd0);
        rst_n = 1'b1;

        // nop at 0
        g0 = gq.size();
        wait_valid("nop", n);
        chk("nop_latency", 64'(n), 64'd3);
        chk("nop_reqs", 64'(gq.size() - g0), 64'd1);
        chk("nop_addr", gq[g0], 64'h0);
        chk("nop_icode", {60'd0, out_icode}, 64'h1);
        chk("nop_valp", out_valp, 64'h1);
        chk("nop_ra", {60'd0, out_ra}, 64'hF);
        chk("nop_rb", {60'd0, out_rb}, 64'hF);
        chk("nop_stat", {62'd0, stat}, 64'd0);
        accept();
        chk("nop_next_req", {63'd0, imem_bus.req}, 64'd1);
        chk("nop_next_addr", imem_bus.addr, 64'h1);

        // irmovq at 0x100, redirected while the read of address 1 is granted
        redirect(64'h100);
        g0 = gq.size();
        wait_valid("irmov", n);
        chk("irmov_reqs", 64'(gq.size() - g0), 64'd10);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) if (gq[g0 + i] !== 64'h100 + 64'(i)) ok = 1'b0;
        chk("irmov_addrs", {63'd0, ok}, 64'd1);
        chk("irmov_icode", {60'd0, out_icode}, 64'h3);
        chk("irmov_ra", {60'd0, out_ra}, 64'hF);
        chk("irmov_rb", {60'd0, out_rb}, 64'h2);
        chk("irmov_valc", out_valc, 64'h0807060504030201);
        chk("irmov_pc", out_pc, 64'h100);
        chk("irmov_valp", out_valp, 64'h10A);
        chk("irmov_stat", {62'd0, stat}, 64'd0);

        // Hold off decode for 5 cycles
        g0 = gq.size();
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!out_valid || out_valc !== 64'h0807060504030201 || out_rb !== 4'h2) ok = 1'b0;
            if (imem_bus.req) ok = 1'b0;
        end
        chk("stall_stable", {63'd0, ok}, 64'd1);
        chk("stall_no_grant", 64'(gq.size() - g0), 64'd0);
        accept();
        chk("after_stall_addr", imem_bus.addr, 64'h10A);

        // halt at 0x10A
        wait_valid("halt", n);
        chk("halt_stat", {62'd0, stat}, 64'd1);
        chk("halt_pc", out_pc, 64'h10A);
        chk("halt_valp", out_valp, 64'h10B);
        accept();
        count_req(20, reqs);
        chk("halt_no_req", 64'(reqs), 64'd0);
        chk("halt_no_valid", {63'd0, out_valid}, 64'd0);

        // Invalid icode C
        redirect(64'h200);
        g0 = gq.size();
        wait_valid("ins", n);
        chk("ins_stat", {62'd0, stat}, 64'd2);
        chk("ins_icode", {60'd0, out_icode}, 64'hC);
        chk("ins_reqs", 64'(gq.size() - g0), 64'd1);
        accept();
        count_req(5, reqs);
        chk("ins_no_req", 64'(reqs), 64'd0);

        // mrmovq with address fault on valC byte 3
        err_en   = 1'b1;
        err_addr = 64'h305;
        redirect(64'h300);
        g0 = gq.size();
        wait_valid("adr", n);
        chk("adr_stat", {62'd0, stat}, 64'd3);
        chk("adr_reqs", 64'(gq.size() - g0), 64'd6);
        chk("adr_last_addr", gq[g0 + 5], 64'h305);
        chk("adr_regs", {56'd0, out_ra, out_rb}, 64'h12);
        accept();
        count_req(5, reqs);
        chk("adr_no_req", 64'(reqs), 64'd0);
        err_en = 1'b0;

        // Redirect during valC byte 5 with a slow read in flight
        lat = 3;
        redirect(64'h400);
        g0 = gq.size();
        n = 0;
        while ((gq.size() - g0) < 8 && n < 200) begin
            tick();
            n++;
        end
        chk("inflight_grants", 64'(gq.size() - g0), 64'd8);
        chk("inflight_addr", gq[g0 + 7], 64'h407);
        redirect(64'h40);
        chk("redir_valid_low", {63'd0, out_valid}, 64'd0);
        g1 = gq.size();
        viol = 0;
        stale = 1'b0;
        n = 0;
        while (gq.size() == g1 && n < 50) begin
            if (imem_bus.req && !stale) viol++;
            if (imem_bus.rvalid) stale = 1'b1;
            tick();
            n++;
        end
        chk("stale_seen", {63'd0, stale}, 64'd1);
        chk("no_req_before_stale", 64'(viol), 64'd0);
        chk("redir_addr", gq[g1], 64'h40);
        wait_valid("redir", n);
        chk("redir_icode", {60'd0, out_icode}, 64'h1);
        chk("redir_pc", out_pc, 64'h40);
        chk("redir_valp", out_valp, 64'h41);

        // Redirect and accept in the same cycle: redirect wins
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("race_valid_low", {63'd0, out_valid}, 64'd0);
        chk("race_addr", imem_bus.addr, 64'h0);
        wait_valid("race", n);
        chk("race_pc", out_pc, 64'h0);
        chk("race_icode", {60'd0, out_icode}, 64'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
